mmio_timer: RTL and testbench

- Memory-mapped timer/GPIO peripheral on the single-cycle MIPS data port, downstream of the core.
- Snoops the core's memwrite/memaddr/memwritedata; returns read data that the top-level muxes with data-RAM read data into memreaddata.
- Provides a prescaled 32-bit up-counter with compare, auto-reload/one-shot mode, a sticky match flag, an interrupt line and a GPIO output register.
- Reads are combinational so single-cycle lw completes in one cycle. Writes commit on the clock edge.

---
 rtl/mmio_timer.sv | 145 ++++++++++++++
 tb/tb_mmio_timer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled timer with compare/match interrupt and a GPIO output register.
// Reads are combinational off the core's data address; writes commit on the rising clock edge.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0000,
  parameter int          GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [31:0]       memaddr,
  input  logic [31:0]       memwritedata,
  output logic              sel,
  output logic [31:0]       rdata,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_COUNT    = 3'd1;
  localparam logic [2:0] IDX_COMPARE  = 3'd2;
  localparam logic [2:0] IDX_STATUS   = 3'd3;
  localparam logic [2:0] IDX_GPIO     = 3'd4;
  localparam logic [2:0] IDX_PRESCALE = 3'd5;

  logic              r_en;
  logic              r_autoreload;
  logic              r_irqen;
  logic [31:0]       r_count;
  logic [31:0]       r_compare;
  logic              r_match;
  logic [GPIO_W-1:0] r_gpio;
  logic [15:0]       r_prescale;
  logic [15:0]       r_pcnt;

  logic        w_sel;
  logic [2:0]  w_idx;
  logic        w_we;
  logic        w_wr_ctrl;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_wr_gpio;
  logic        w_wr_prescale;
  logic        w_tick;
  logic        w_hit;
  logic [31:0] w_gpio_ext;
  logic        w_unused_addr;

  assign w_sel         = (memaddr[31:5] == BASE_ADDR[31:5]);
  assign w_idx         = memaddr[4:2];
  assign w_we          = memwrite & w_sel;
  assign w_wr_ctrl     = w_we && (w_idx == IDX_CTRL);
  assign w_wr_count    = w_we && (w_idx == IDX_COUNT);
  assign w_wr_compare  = w_we && (w_idx == IDX_COMPARE);
  assign w_wr_status   = w_we && (w_idx == IDX_STATUS);
  assign w_wr_gpio     = w_we && (w_idx == IDX_GPIO);
  assign w_wr_prescale = w_we && (w_idx == IDX_PRESCALE);
  assign w_unused_addr = &{1'b0, memaddr[1:0]};

  // A tick is a counter step; a hit is a tick that lands on COMPARE.
  assign w_tick = r_en && (r_pcnt == r_prescale);
  assign w_hit  = w_tick && (r_count == r_compare);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pcnt <= '0;
    end else if (w_wr_ctrl || w_wr_prescale) begin
      r_pcnt <= '0;
    end else if (r_en) begin
      r_pcnt <= w_tick ? 16'd0 : r_pcnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en         <= 1'b0;
      r_autoreload <= 1'b0;
      r_irqen      <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_en         <= memwritedata[0];
      r_autoreload <= memwritedata[1];
      r_irqen      <= memwritedata[2];
    end else if (w_hit && !r_autoreload) begin
      r_en <= 1'b0;
    end
  end

  // Software COUNT write overrides whatever the tick would have done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (w_wr_count) begin
      r_count <= memwritedata;
    end else if (w_hit) begin
      if (r_autoreload) r_count <= '0;
    end else if (w_tick) begin
      r_count <= r_count + 32'd1;
    end
  end

  // Hardware match set beats a same-edge write-1-to-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_match <= 1'b0;
    end else if (w_hit) begin
      r_match <= 1'b1;
    end else if (w_wr_status && memwritedata[0]) begin
      r_match <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_compare  <= 32'hFFFF_FFFF;
      r_gpio     <= '0;
      r_prescale <= '0;
    end else begin
      if (w_wr_compare)  r_compare  <= memwritedata;
      if (w_wr_gpio)     r_gpio     <= memwritedata[GPIO_W-1:0];
      if (w_wr_prescale) r_prescale <= memwritedata[15:0];
    end
  end

  assign w_gpio_ext = 32'(r_gpio);

  always_comb begin
    rdata = '0;
    if (w_sel) begin
      case (w_idx)
        IDX_CTRL:     rdata = {29'd0, r_irqen, r_autoreload, r_en};
        IDX_COUNT:    rdata = r_count;
        IDX_COMPARE:  rdata = r_compare;
        IDX_STATUS:   rdata = {31'd0, r_match};
        IDX_GPIO:     rdata = w_gpio_ext;
        IDX_PRESCALE: rdata = {16'd0, r_prescale};
        default:      rdata = '0;
      endcase
    end
  end

  assign sel      = w_sel;
  assign gpio_out = r_gpio;
  assign irq      = r_match & r_irqen;

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: directed scenarios plus randomized register traffic against a behavioural model.
`timescale 1ns/1ps
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] memaddr = 32'd0;
  logic [31:0] memwritedata = 32'd0;
  logic        sel;
  logic [31:0] rdata;
  logic [7:0]  gpio_out;
  logic        irq;

  mmio_timer #(.BASE_ADDR(BASE), .GPIO_W(8)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memaddr(memaddr),
    .memwritedata(memwritedata), .sel(sel), .rdata(rdata),
    .gpio_out(gpio_out), .irq(irq)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_en, m_ar, m_ie, m_match;
  logic [31:0] m_count, m_cmp;
  logic [7:0]  m_gpio;
  logic [15:0] m_pre, m_pcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_en = 0; m_ar = 0; m_ie = 0; m_match = 0;
    m_count = 32'd0; m_cmp = 32'hFFFF_FFFF; m_gpio = 8'd0; m_pre = 16'd0; m_pcnt = 16'd0;
  endtask

  function automatic logic [31:0] m_read(input int idx);
    case (idx)
      0: return {29'd0, m_ie, m_ar, m_en};
      1: return m_count;
      2: return m_cmp;
      3: return {31'd0, m_match};
      4: return {24'd0, m_gpio};
      5: return {16'd0, m_pre};
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock: evaluate the spec's rules on pre-edge state, then commit after the edge.
  task automatic step();
    bit hit, tick, fire;
    int idx;
    bit n_en, n_ar, n_ie, n_match;
    logic [31:0] n_count, n_cmp, wd;
    logic [7:0] n_gpio;
    logic [15:0] n_pre, n_pcnt;
    wd = memwritedata;
    hit = memwrite && (memaddr[31:5] == BASE[31:5]);
    idx = int'(memaddr[4:2]);
    tick = m_en && (m_pcnt == m_pre);
    fire = tick && (m_count == m_cmp);
    n_en = m_en; n_ar = m_ar; n_ie = m_ie; n_match = m_match;
    n_count = m_count; n_cmp = m_cmp; n_gpio = m_gpio; n_pre = m_pre; n_pcnt = m_pcnt;
    if (m_en) n_pcnt = tick ? 16'd0 : 16'(m_pcnt + 16'd1);
    if (fire) begin
      n_match = 1;
      if (m_ar) n_count = 32'd0;
      else n_en = 0;
    end else if (tick) begin
      n_count = m_count + 32'd1;
    end
    if (hit) begin
      case (idx)
        0: begin n_en = wd[0]; n_ar = wd[1]; n_ie = wd[2]; n_pcnt = 16'd0; end
        1: n_count = wd;
        2: n_cmp = wd;
        3: if (wd[0] && !fire) n_match = 0;
        4: n_gpio = wd[7:0];
        5: begin n_pre = wd[15:0]; n_pcnt = 16'd0; end
        default: ;
      endcase
    end
    @(posedge clk);
    m_en = n_en; m_ar = n_ar; m_ie = n_ie; m_match = n_match;
    m_count = n_count; m_cmp = n_cmp; m_gpio = n_gpio; m_pre = n_pre; m_pcnt = n_pcnt;
    #1;
    chk("irq", 32'(irq), 32'(m_match & m_ie));
    chk("gpio_out", 32'(gpio_out), {24'd0, m_gpio});
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    memwrite = 1'b1; memaddr = addr; memwritedata = d;
    step();
    memwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic rd(input int idx);
    memaddr = BASE + 32'(idx * 4);
    #1;
    chk($sformatf("rd%0d", idx), rdata, m_read(idx));
  endtask

  task automatic rdc(input string tag, input int idx, input logic [31:0] exp);
    memaddr = BASE + 32'(idx * 4);
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    logic [31:0] rst_vals [8];
    rst_vals = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    m_reset();
    repeat (3) @(posedge clk);
    #5 reset = 1'b1;

    // Reset state
    for (int i = 0; i < 8; i++) rdc($sformatf("rst_idx%0d", i), i, rst_vals[i]);
    chk("rst_gpio", 32'(gpio_out), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    memaddr = 32'h0000_1000;
    #1;
    chk("miss_sel", 32'(sel), 32'd0);
    chk("miss_rdata", rdata, 32'd0);

    // GPIO
    wr(BASE + 32'd16, 32'h1234_56A5);
    chk("gpio_val", 32'(gpio_out), 32'h0000_00A5);
    rdc("gpio_rd", 4, 32'h0000_00A5);
    memaddr = BASE + 32'd32;
    #1;
    chk("out_sel", 32'(sel), 32'd0);
    wr(BASE + 32'd32, 32'h0000_00FF);
    chk("out_gpio", 32'(gpio_out), 32'h0000_00A5);

    // Auto-reload with prescale 3
    wr(BASE + 32'd20, 32'd3);
    wr(BASE + 32'd8, 32'd2);
    wr(BASE + 32'd0, 32'd7);
    for (int k = 1; k <= 12; k++) begin
      step();
      rdc("ar_count", 1, 32'((k / 4) % 3));
      chk("ar_irq", 32'(irq), 32'(k >= 12));
    end
    rdc("ar_match", 3, 32'd1);
    for (int k = 0; k < 10; k++) begin step(); rd(1); rd(3); end

    // One-shot and write-1-to-clear
    wr(BASE + 32'd0, 32'd0);
    wr(BASE + 32'd12, 32'd1);
    wr(BASE + 32'd4, 32'd0);
    wr(BASE + 32'd20, 32'd0);
    wr(BASE + 32'd8, 32'd5);
    wr(BASE + 32'd0, 32'd1);
    idle(6);
    rdc("os_match", 3, 32'd1);
    rdc("os_count", 1, 32'd5);
    rdc("os_ctrl", 0, 32'd0);
    idle(2);
    rdc("os_hold", 1, 32'd5);
    wr(BASE + 32'd12, 32'd1);
    rdc("w1c", 3, 32'd0);
    wr(BASE + 32'd12, 32'd0);
    wr(BASE + 32'd0, 32'd1);
    wr(BASE + 32'd12, 32'd1);
    rdc("set_beats_clr", 3, 32'd1);
    rdc("os_ctrl2", 0, 32'd0);

    // Wrap and software-write priority
    wr(BASE + 32'd12, 32'd1);
    wr(BASE + 32'd4, 32'hFFFF_FFFF);
    wr(BASE + 32'd8, 32'd10);
    wr(BASE + 32'd0, 32'd1);
    step();
    rdc("wrap_count", 1, 32'd0);
    rdc("wrap_match", 3, 32'd0);
    wr(BASE + 32'd4, 32'd7);
    rdc("sw_wins", 1, 32'd7);
    step();
    rdc("after_sw", 1, 32'd8);

    // Randomized register traffic
    for (int it = 0; it < 400; it++) begin
      int r, idx;
      logic [31:0] addr, d;
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        step();
      end else begin
        idx = int'($urandom_range(0, 7));
        case (idx)
          0: d = $urandom_range(0, 7);
          1, 2: d = $urandom_range(0, 12);
          5: d = $urandom_range(0, 3);
          default: d = $urandom;
        endcase
        addr = BASE + 32'(idx * 4);
        if (r == 9) addr = (it % 2 == 0) ? addr + 32'd32 : addr - 32'd32;
        wr(addr, d);
      end
      rd(int'($urandom_range(0, 7)));
      rd(1);
      chk("rnd_sel", 32'(sel), 32'd1);
    end

    // Asynchronous reset mid-count
    wr(BASE + 32'd0, 32'd0);
    wr(BASE + 32'd20, 32'd0);
    wr(BASE + 32'd8, 32'h102);
    wr(BASE + 32'd4, 32'h100);
    wr(BASE + 32'd0, 32'd7);
    idle(4);
    chk("pre_rst_irq", 32'(irq), 32'd1);
    #5 reset = 1'b0;
    #1;
    rdc("arst_count", 1, 32'd0);
    rdc("arst_ctrl", 0, 32'd0);
    rdc("arst_cmp", 2, 32'hFFFF_FFFF);
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_gpio", 32'(gpio_out), 32'd0);
    m_reset();
    @(posedge clk);
    #5 reset = 1'b1;
    idle(5);
    rdc("idle_count", 1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
